// File: rtl/addsub_if.sv
// Operand/result handshake bundle for addsub_pipe, including the sticky overflow status and its clear.
// The slave modport is the adder's view; the master modport is the producer/consumer side.
interface addsub_if #(
   parameter int W = 8
);
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         sub;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] s;
   logic         cout;
   logic         ovf;
   logic         ovf_sticky;
   logic         ovf_clr;

   modport master (
      output in_valid, a, b, sub, out_ready, ovf_clr,
      input  in_ready, out_valid, s, cout, ovf, ovf_sticky
   );

   modport slave (
      input  in_valid, a, b, sub, out_ready, ovf_clr,
      output in_ready, out_valid, s, cout, ovf, ovf_sticky
   );
endinterface

// File: rtl/addsub_pipe.sv
// Pipelined W-bit adder-subtractor, one SEG-bit carry-chained segment per stage, valid/ready on both sides.
// Optional build macro SAT_EN clamps overflowing results to the signed limit instead of wrapping.
module addsub_pipe #(
   parameter int W   = 8,
   parameter int SEG = 4
) (
   input  logic    clk,
   input  logic    rst_n,
   addsub_if.slave io
);
   localparam int STAGES = W / SEG;
   localparam int LAST   = STAGES - 1;

   // Per-stage pipeline state: operands travel alongside the partial sum.
   logic         st_v   [STAGES];
   logic [W-1:0] st_a   [STAGES];
   logic [W-1:0] st_bx  [STAGES];
   logic [W-1:0] st_sum [STAGES];
   logic         st_c   [STAGES];

   logic adv;
   assign adv         = !st_v[LAST] || io.out_ready;
   assign io.in_ready = adv;

   generate
      for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
         logic         v_in;
         logic [W-1:0] a_in;
         logic [W-1:0] bx_in;
         logic [W-1:0] sum_in;
         logic         c_in;
         logic [SEG:0] seg_sum;
         logic [W-1:0] sum_next;

         logic         v_reg;
         logic [W-1:0] a_reg;
         logic [W-1:0] bx_reg;
         logic [W-1:0] sum_reg;
         logic         c_reg;

         if (gi == 0) begin : g_head
            // Subtraction is A + ~B + 1; the +1 enters as stage 0's carry-in.
            assign v_in   = io.in_valid;
            assign a_in   = io.a;
            assign bx_in  = io.b ^ {W{io.sub}};
            assign sum_in = '0;
            assign c_in   = io.sub;
         end else begin : g_body
            assign v_in   = st_v[gi-1];
            assign a_in   = st_a[gi-1];
            assign bx_in  = st_bx[gi-1];
            assign sum_in = st_sum[gi-1];
            assign c_in   = st_c[gi-1];
         end

         always_comb begin
            seg_sum  = {1'b0, a_in[gi*SEG +: SEG]} + {1'b0, bx_in[gi*SEG +: SEG]}
                     + {{SEG{1'b0}}, c_in};
            sum_next = sum_in;
            sum_next[gi*SEG +: SEG] = seg_sum[SEG-1:0];
         end

         always_ff @(posedge clk) begin
            if (!rst_n) begin
               v_reg   <= 1'b0;
               a_reg   <= '0;
               bx_reg  <= '0;
               sum_reg <= '0;
               c_reg   <= 1'b0;
            end else if (adv) begin
               v_reg   <= v_in;
               a_reg   <= a_in;
               bx_reg  <= bx_in;
               sum_reg <= sum_next;
               c_reg   <= seg_sum[SEG];
            end
         end

         assign st_v[gi]   = v_reg;
         assign st_a[gi]   = a_reg;
         assign st_bx[gi]  = bx_reg;
         assign st_sum[gi] = sum_reg;
         assign st_c[gi]   = c_reg;
      end
   endgenerate

   logic [W-1:0] sum_out;
   logic         carry_msb;
   logic         ovf_out;
   logic         ovf_sticky_reg;

   // Carry into the MSB is recovered from the MSB's sum bit and its two addend bits.
   assign sum_out   = st_sum[LAST];
   assign carry_msb = sum_out[W-1] ^ st_a[LAST][W-1] ^ st_bx[LAST][W-1];
   assign ovf_out   = carry_msb ^ st_c[LAST];

   assign io.out_valid  = st_v[LAST];
   assign io.cout       = st_c[LAST];
   assign io.ovf        = ovf_out;
   assign io.ovf_sticky = ovf_sticky_reg;

`ifdef SAT_EN
   always_comb begin
      io.s = sum_out;
      if (ovf_out) begin
         io.s = st_a[LAST][W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
      end
   end
`else
   assign io.s = sum_out;
`endif

   // A delivered overflow beat takes priority over a simultaneous clear.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ovf_sticky_reg <= 1'b0;
      end else if (st_v[LAST] && io.out_ready && ovf_out) begin
         ovf_sticky_reg <= 1'b1;
      end else if (io.ovf_clr) begin
         ovf_sticky_reg <= 1'b0;
      end
   end
endmodule

// File: tb/tb_addsub_pipe.sv
// Self-checking bench for addsub_pipe: directed test-plan vectors, stall stream, sticky flag,
// randomized traffic against an integer-arithmetic scoreboard, and mid-stream reset.
module tb_addsub_pipe;
   localparam int W      = 8;
   localparam int SEG    = 4;
   localparam int STAGES = W / SEG;

   typedef struct packed {
      logic [W-1:0] s;
      logic         cout;
      logic         ovf;
   } res_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_tests = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   addsub_if #(.W(W)) bus ();

   addsub_pipe #(.W(W), .SEG(SEG)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .io    (bus)
   );

   // Reference: signed and unsigned results from plain integer arithmetic.
   function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic sb);
      int   ux;
      int   uy;
      int   sx;
      int   sy;
      int   sr;
      int   ur;
      res_t r;
      ux = int'(x);
      uy = int'(y);
      sx = int'($signed(x));
      sy = int'($signed(y));
      sr = sb ? sx - sy : sx + sy;
      ur = sb ? ux - uy : ux + uy;
      r.s    = ur[W-1:0];
      r.cout = sb ? (ux >= uy) : (ur >= (1 << W));
      r.ovf  = (sr > (1 << (W-1)) - 1) || (sr < -(1 << (W-1)));
`ifdef SAT_EN
      if (r.ovf) r.s = (sr > 0) ? {1'b0, {(W-1){1'b1}}} : {1'b1, {(W-1){1'b0}}};
`endif
      return r;
   endfunction

   // Samples handshake and outputs just before the next edge, then advances one clock.
   task automatic tick(output bit acc, output bit dlv, output bit vld, output bit rdy,
                       output res_t got);
      #1;
      acc = bus.in_valid && bus.in_ready;
      dlv = bus.out_valid && bus.out_ready;
      vld = bus.out_valid;
      rdy = bus.in_ready;
      got = {bus.s, bus.cout, bus.ovf};
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.in_valid  = 1'b0;
      bus.a         = '0;
      bus.b         = '0;
      bus.sub       = 1'b0;
      bus.out_ready = 1'b1;
      bus.ovf_clr   = 1'b0;
   endtask

   task automatic clear_sticky();
      bit acc, dlv, vld, rdy;
      res_t got;
      bus.ovf_clr = 1'b1;
      tick(acc, dlv, vld, rdy, got);
      bus.ovf_clr = 1'b0;
   endtask

   task automatic test_reset();
      bit acc, dlv, vld, rdy;
      res_t got;
      rst_n        = 1'b0;
      bus.in_valid = 1'b1;
      bus.a        = 8'd100;
      bus.b        = 8'd28;
      repeat (3) tick(acc, dlv, vld, rdy, got);
      n_tests++;
      if (bus.out_valid !== 1'b0) begin
         n_fail++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid);
      end
      n_tests++;
      if (bus.s !== '0 || bus.cout !== 1'b0 || bus.ovf !== 1'b0) begin
         n_fail++; $display("FAIL reset_outputs got s=%h cout=%b ovf=%b exp 00/0/0", bus.s, bus.cout, bus.ovf);
      end
      n_tests++;
      if (bus.ovf_sticky !== 1'b0) begin
         n_fail++; $display("FAIL reset_sticky got=%b exp=0", bus.ovf_sticky);
      end
      rst_n = 1'b1;
      idle_inputs();
      tick(acc, dlv, vld, rdy, got);
      n_tests++;
      if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
         n_fail++; $display("FAIL reset_release got in_ready=%b out_valid=%b exp 1/0", bus.in_ready, bus.out_valid);
      end
      $display("[TB] test_reset done");
   endtask

   task automatic test_directed();
      logic [W-1:0] va   [4] = '{8'd100, 8'd100, 8'd5, 8'h80};
      logic [W-1:0] vb   [4] = '{8'd27, 8'd28, 8'd7, 8'd1};
      logic         vs   [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
`ifdef SAT_EN
      logic [W-1:0] es   [4] = '{8'h7F, 8'h7F, 8'hFE, 8'h80};
`else
      logic [W-1:0] es   [4] = '{8'h7F, 8'h80, 8'hFE, 8'h7F};
`endif
      logic         ec   [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
      logic         eo   [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
      bit   acc, dlv, vld, rdy;
      res_t got;
      int   lat;
      for (int i = 0; i < 4; i++) begin
         clear_sticky();
         bus.in_valid  = 1'b1;
         bus.a         = va[i];
         bus.b         = vb[i];
         bus.sub       = vs[i];
         bus.out_ready = 1'b1;
         tick(acc, dlv, vld, rdy, got);
         bus.in_valid = 1'b0;
         n_tests++;
         if (!acc) begin
            n_fail++; $display("FAIL dir%0d_accept got=0 exp=1", i);
         end
         lat = 1;
         while (bus.out_valid !== 1'b1 && lat < 10) begin
            tick(acc, dlv, vld, rdy, got);
            lat++;
         end
         n_tests++;
         if (lat != STAGES) begin
            n_fail++; $display("FAIL dir%0d_latency got=%0d exp=%0d", i, lat, STAGES);
         end
         n_tests++;
         if (bus.s !== es[i] || bus.cout !== ec[i] || bus.ovf !== eo[i]) begin
            n_fail++;
            $display("FAIL dir%0d_result got s=%h cout=%b ovf=%b exp s=%h cout=%b ovf=%b",
                     i, bus.s, bus.cout, bus.ovf, es[i], ec[i], eo[i]);
         end
         tick(acc, dlv, vld, rdy, got);
         n_tests++;
         if (bus.ovf_sticky !== eo[i]) begin
            n_fail++; $display("FAIL dir%0d_sticky got=%b exp=%b", i, bus.ovf_sticky, eo[i]);
         end
         $display("[TB] directed a=%h b=%h sub=%b -> s=%h cout=%b ovf=%b lat=%0d",
                  va[i], vb[i], vs[i], got.s, got.cout, got.ovf, lat);
      end
   endtask

   task automatic test_stall_stream();
      res_t exp_q[$];
      res_t exp;
      res_t got;
      res_t prev_got;
      bit   acc, dlv, vld, rdy;
      bit   prev_stall;
      int   sent;
      int   ndel;
      int   cyc;
      sent = 0;
      ndel = 0;
      cyc  = 0;
      prev_stall = 1'b0;
      prev_got   = '0;
      while (ndel < 10 && cyc < 60) begin
         bus.in_valid  = (sent < 10);
         bus.a         = W'(sent);
         bus.b         = W'(sent);
         bus.sub       = 1'b0;
         bus.out_ready = !(cyc >= 3 && cyc <= 5);
         tick(acc, dlv, vld, rdy, got);
         if (cyc >= 3 && cyc <= 5) begin
            n_tests++;
            if (rdy !== 1'b0) begin
               n_fail++; $display("FAIL stall_in_ready cyc=%0d got=%b exp=0", cyc, rdy);
            end
         end
         if (prev_stall) begin
            n_tests++;
            if (!vld || got !== prev_got) begin
               n_fail++; $display("FAIL stall_hold cyc=%0d got vld=%b res=%h exp vld=1 res=%h", cyc, vld, got, prev_got);
            end
         end
         if (acc) begin
            exp_q.push_back(model(W'(sent), W'(sent), 1'b0));
            sent++;
         end
         if (dlv) begin
            n_tests++;
            if (exp_q.size() == 0) begin
               n_fail++; $display("FAIL stream_extra got s=%h exp none", got.s);
            end else begin
               exp = exp_q.pop_front();
               if (got !== exp || got.s !== W'(2 * ndel)) begin
                  n_fail++; $display("FAIL stream_beat%0d got s=%h exp s=%h", ndel, got.s, W'(2 * ndel));
               end
            end
            $display("[TB] stream beat %0d s=%0d", ndel, got.s);
            ndel++;
         end
         prev_stall = vld && !dlv;
         prev_got   = got;
         cyc++;
      end
      n_tests++;
      if (ndel != 10) begin
         n_fail++; $display("FAIL stream_count got=%0d exp=10", ndel);
      end
      idle_inputs();
   endtask

   task automatic test_sticky();
      bit   acc, dlv, vld, rdy;
      res_t got;
      int   guard;
      clear_sticky();
      for (int k = 0; k < 2; k++) begin
         bus.in_valid  = 1'b1;
         bus.a         = 8'd100;
         bus.b         = 8'd28;
         bus.sub       = 1'b0;
         bus.out_ready = 1'b1;
         tick(acc, dlv, vld, rdy, got);
         bus.in_valid = 1'b0;
         dlv   = 1'b0;
         guard = 0;
         while (!dlv && guard < 10) begin
            // Second beat: clear is pulsed exactly on its delivery cycle.
            bus.ovf_clr = (k == 1) && bus.out_valid;
            tick(acc, dlv, vld, rdy, got);
            guard++;
         end
         bus.ovf_clr = 1'b0;
         n_tests++;
         if (!dlv || bus.ovf_sticky !== 1'b1) begin
            n_fail++; $display("FAIL sticky_set%0d got dlv=%b sticky=%b exp 1/1", k, dlv, bus.ovf_sticky);
         end
         $display("[TB] sticky beat %0d delivered ovf=%b sticky=%b", k, got.ovf, bus.ovf_sticky);
      end
      clear_sticky();
      n_tests++;
      if (bus.ovf_sticky !== 1'b0) begin
         n_fail++; $display("FAIL sticky_clear got=%b exp=0", bus.ovf_sticky);
      end
      $display("[TB] sticky clear alone -> %b", bus.ovf_sticky);
   endtask

   task automatic test_random();
      res_t exp_q[$];
      res_t exp;
      res_t got;
      bit   acc, dlv, vld, rdy;
      logic sticky_exp;
      int   guard;
      clear_sticky();
      sticky_exp = 1'b0;
      for (int c = 0; c < 300; c++) begin
         bus.in_valid  = ($urandom % 4) != 0;
         bus.a         = W'($urandom);
         bus.b         = W'($urandom);
         bus.sub       = 1'($urandom % 2);
         bus.out_ready = ($urandom % 3) != 0;
         bus.ovf_clr   = ($urandom % 8) == 0;
         tick(acc, dlv, vld, rdy, got);
         if (acc) exp_q.push_back(model(bus.a, bus.b, bus.sub));
         if (dlv) begin
            n_tests++;
            if (exp_q.size() == 0) begin
               n_fail++; $display("FAIL rand_extra cyc=%0d got=%h exp none", c, got);
               exp = got;
            end else begin
               exp = exp_q.pop_front();
               if (got !== exp) begin
                  n_fail++;
                  $display("FAIL rand_beat cyc=%0d got s=%h cout=%b ovf=%b exp s=%h cout=%b ovf=%b",
                           c, got.s, got.cout, got.ovf, exp.s, exp.cout, exp.ovf);
               end
            end
            $display("[TB] rand cyc=%0d s=%h cout=%b ovf=%b", c, got.s, got.cout, got.ovf);
            if (exp.ovf) sticky_exp = 1'b1;
            else if (bus.ovf_clr) sticky_exp = 1'b0;
         end else if (bus.ovf_clr) begin
            sticky_exp = 1'b0;
         end
         n_tests++;
         if (bus.ovf_sticky !== sticky_exp) begin
            n_fail++; $display("FAIL rand_sticky cyc=%0d got=%b exp=%b", c, bus.ovf_sticky, sticky_exp);
         end
      end
      idle_inputs();
      guard = 0;
      while (exp_q.size() != 0 && guard < 20) begin
         tick(acc, dlv, vld, rdy, got);
         if (dlv) begin
            exp = exp_q.pop_front();
            n_tests++;
            if (got !== exp) begin
               n_fail++; $display("FAIL rand_drain got=%h exp=%h", got, exp);
            end
         end
         guard++;
      end
      n_tests++;
      if (exp_q.size() != 0 || bus.out_valid !== 1'b0) begin
         n_fail++; $display("FAIL rand_drain_empty got pending=%0d out_valid=%b exp 0/0", exp_q.size(), bus.out_valid);
      end
   endtask

   task automatic test_reset_midstream();
      bit   acc, dlv, vld, rdy;
      res_t got;
      int   n_acc;
      bit   any_vld;
      int   guard;
      bus.in_valid  = 1'b1;
      bus.a         = 8'd100;
      bus.b         = 8'd28;
      bus.sub       = 1'b0;
      bus.out_ready = 1'b1;
      tick(acc, dlv, vld, rdy, got);
      bus.in_valid = 1'b0;
      dlv   = 1'b0;
      guard = 0;
      while (!dlv && guard < 10) begin
         tick(acc, dlv, vld, rdy, got);
         guard++;
      end
      n_tests++;
      if (bus.ovf_sticky !== 1'b1) begin
         n_fail++; $display("FAIL midrst_presticky got=%b exp=1", bus.ovf_sticky);
      end
      n_acc = 0;
      bus.in_valid  = 1'b1;
      bus.out_ready = 1'b0;
      for (int k = 0; k < 2; k++) begin
         bus.a = W'(k + 1);
         bus.b = W'(k + 1);
         tick(acc, dlv, vld, rdy, got);
         if (acc) n_acc++;
      end
      n_tests++;
      if (n_acc != 2) begin
         n_fail++; $display("FAIL midrst_inflight got=%0d exp=2", n_acc);
      end
      bus.in_valid = 1'b0;
      rst_n = 1'b0;
      tick(acc, dlv, vld, rdy, got);
      rst_n = 1'b1;
      n_tests++;
      if (bus.out_valid !== 1'b0 || bus.ovf_sticky !== 1'b0) begin
         n_fail++; $display("FAIL midrst_after got out_valid=%b sticky=%b exp 0/0", bus.out_valid, bus.ovf_sticky);
      end
      bus.out_ready = 1'b1;
      any_vld = 1'b0;
      repeat (6) begin
         tick(acc, dlv, vld, rdy, got);
         any_vld |= vld;
      end
      n_tests++;
      if (any_vld) begin
         n_fail++; $display("FAIL midrst_stale got out_valid=1 exp=0");
      end
      $display("[TB] midstream reset: in_flight=%0d stale=%b", n_acc, any_vld);
   endtask

   initial begin
      idle_inputs();
      @(posedge clk);
      #1;
      test_reset();
      test_directed();
      test_stall_stream();
      test_sticky();
      test_random();
      test_reset_midstream();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/addsub_pipe.md
Name: addsub_pipe

Overview:
Parametrised, pipelined signed/unsigned adder-subtractor that supersedes the single-stage registered add/sub block. The W-bit operation is split into SEG-bit carry-chained segments, one segment per pipeline stage, so wide datapaths close timing. A valid/ready handshake on both sides supports stalls. The block reports carry-out, signed overflow and a sticky overflow status, and sits between operand registers and result consumers in the lab datapaths.

Parameters:
W, 8, operand/result width in bits; must be a multiple of SEG.
SEG, 4, segment width per pipeline stage; STAGES = W/SEG (1 allowed).

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  reset, synchronous, active-low
in_valid  input  1  operand beat present
in_ready  output  1  block accepts beat this cycle
a  input  W  operand A
b  input  W  operand B
sub  input  1  0 = A+B, 1 = A-B
out_valid  output  1  result beat present
out_ready  input  1  consumer accepts result
s  output  W  result
cout  output  1  carry-out (subtract: 1 = no borrow, i.e. A >= B unsigned)
ovf  output  1  signed overflow of this result
ovf_sticky  output  1  set by any delivered ovf=1 beat, held until cleared
ovf_clr  input  1  clears ovf_sticky

Behaviour:
- Reset: one clock and one reset, named clk and rst_n; reset is synchronous, active-low. While rst_n=0 at a clk edge: all stage valids, out_valid, s, cout, ovf and ovf_sticky go to 0. Reset mid-stream discards all in-flight beats; there is no partial output.
- Arithmetic: the block computes A + (B XOR {W{sub}}) + sub. Stage k (0..STAGES-1) adds segment k using the carry registered from stage k-1; stage 0 uses carry-in = sub. Already-computed lower segments and not-yet-used upper operand segments travel with the beat.
- Flags: cout is the carry out of bit W-1. ovf = carry-in to bit W-1 XOR carry-out of bit W-1.
- Handshake: adv = !out_valid | out_ready; in_ready = adv. All stages shift together when adv=1 and hold otherwise, including bubbles. An input beat is accepted when in_valid & in_ready. A beat is delivered when out_valid & out_ready.
- Latency: STAGES cycles from acceptance to out_valid when unstalled. Throughput is one beat per cycle. s, cout and ovf stay stable while out_valid=1 & out_ready=0.
- Sticky: ovf_sticky sets on delivery of a beat with ovf=1. ovf_clr=1 clears it. If set and clear occur in the same cycle, set wins.
- Beat order is preserved. No beat is dropped or duplicated under any out_ready pattern.

Optional Feature:
SAT_EN. When defined, a beat with ovf=1 has s clamped to the signed limit: 0 followed by W-1 ones if A was non-negative, else 1 followed by W-1 zeros. ovf and cout still report the unclamped result. When undefined, s wraps modulo 2^W. Latency and handshake are identical in both builds.

Test Plan:
W=8,SEG=4; a=100,b=27,sub=0 -> after 2 cycles s=0x7F, ovf=0, cout=0.
a=100,b=28,sub=0 -> s=0x80, ovf=1, ovf_sticky=1 after delivery; with SAT_EN s=0x7F.
a=5,b=7,sub=1 -> s=0xFE, cout=0, ovf=0; a=0x80,b=1,sub=1 -> s=0x7F, ovf=1 (SAT_EN: s=0x80).
Stream of 10 beats a=i,b=i,sub=0; out_ready low for cycles 3-5 -> in_ready low same cycles, outputs 0,2,..,18 in order, held stable while stalled.
Set ovf_sticky, then pulse ovf_clr in the same cycle as another ovf beat delivery -> ovf_sticky stays 1; a later ovf_clr alone -> 0.
rst_n=0 for one cycle with 2 beats in flight -> out_valid=0 next cycle, no stale beat emerges, ovf_sticky=0.
